// File: rtl/quad_encoder_emulator_if.sv
// Step-command handshake between a stimulus source (master) and the
// quadrature encoder emulator (slave).
interface quad_encoder_emulator_if;
    logic       cmd_valid;
    logic       cmd_dir;
    logic [7:0] cmd_steps;
    logic       cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_dir,
        output cmd_steps,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_dir,
        input  cmd_steps,
        output cmd_ready
    );
endinterface

// File: rtl/quad_encoder_emulator.sv
// Quadrature A/B and active-low pushbutton generator driven by step/press
// commands; tracks the net signed edge count emitted.
module quad_encoder_emulator #(
    parameter int STEP_DIV     = 4,
    parameter int PRESS_CYCLES = 2,
    parameter int POS_W        = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    quad_encoder_emulator_if.slave  cmd_if,
    input  logic                    i_btn_req,
    output logic [1:0]              o_quad_out,
    output logic                    o_btn_n,
    output logic                    o_busy,
    output logic                    o_done,
    output logic signed [POS_W-1:0] o_pos
);

    localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int PC_W  = $clog2(PRESS_CYCLES + 1);

    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(STEP_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ZERO   = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
    localparam logic [PC_W-1:0]  PC_LOAD    = PC_W'(PRESS_CYCLES);
    localparam logic [PC_W-1:0]  PC_ONE     = PC_W'(1);
    localparam logic [POS_W-1:0] POS_ONE    = POS_W'(1);

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} step_state_t;
    typedef enum logic {BTN_IDLE = 1'b0, BTN_PRESS = 1'b1} btn_state_t;

    step_state_t      r_state, w_state_nxt;
    logic [DIV_W-1:0] r_div, w_div_nxt;
    logic [7:0]       r_remain, w_remain_nxt;
    logic             r_dir, w_dir_nxt;
    logic [1:0]       r_quad, w_quad_nxt;
    logic [POS_W-1:0] r_pos, w_pos_nxt;
    logic             r_done, w_done_nxt;
    logic             r_busy;
    logic             r_cmd_ready;

    btn_state_t       r_btn_state, w_btn_state_nxt;
    logic [PC_W-1:0]  r_press_cnt, w_press_cnt_nxt;
    logic             r_btn_n;

    // Gray-code walk in (B,A): CW 00->01->11->10, CCW the reverse.
    function automatic logic [1:0] next_phase(input logic [1:0] ph, input logic dir);
        logic [1:0] nxt;
        if (dir) begin
            nxt = {ph[0], ~ph[1]};
        end else begin
            nxt = {~ph[0], ph[1]};
        end
        return nxt;
    endfunction

    // Step FSM next-state: command acceptance, edge pacing and position update.
    always_comb begin
        w_state_nxt  = r_state;
        w_div_nxt    = r_div;
        w_remain_nxt = r_remain;
        w_dir_nxt    = r_dir;
        w_quad_nxt   = r_quad;
        w_pos_nxt    = r_pos;
        w_done_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_if.cmd_valid && r_cmd_ready) begin
                    if (cmd_if.cmd_steps == 8'd0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_dir_nxt    = cmd_if.cmd_dir;
                        w_remain_nxt = cmd_if.cmd_steps;
                        w_div_nxt    = DIV_RELOAD;
                        w_state_nxt  = ST_RUN;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (r_div == DIV_ZERO) begin
                    w_quad_nxt   = next_phase(r_quad, r_dir);
                    w_pos_nxt    = r_dir ? (r_pos + POS_ONE) : (r_pos - POS_ONE);
                    w_remain_nxt = r_remain - 8'd1;
                    w_div_nxt    = DIV_RELOAD;
                    if (r_remain == 8'd1) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end else begin
                    w_div_nxt = r_div - DIV_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Button FSM next-state; a request on the last low cycle starts a fresh press.
    always_comb begin
        w_btn_state_nxt = r_btn_state;
        w_press_cnt_nxt = r_press_cnt;
        case (r_btn_state)
            BTN_IDLE: begin
                if (i_btn_req) begin
                    w_btn_state_nxt = BTN_PRESS;
                    w_press_cnt_nxt = PC_LOAD;
                end else begin
                    w_btn_state_nxt = BTN_IDLE;
                end
            end
            BTN_PRESS: begin
                if (r_press_cnt > PC_ONE) begin
                    w_press_cnt_nxt = r_press_cnt - PC_ONE;
                end else if (i_btn_req) begin
                    w_press_cnt_nxt = PC_LOAD;
                end else begin
                    w_btn_state_nxt = BTN_IDLE;
                    w_press_cnt_nxt = {PC_W{1'b0}};
                end
            end
            default: begin
                w_btn_state_nxt = BTN_IDLE;
            end
        endcase
    end

    // State and output registers for both FSMs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_div       <= DIV_ZERO;
            r_remain    <= 8'd0;
            r_dir       <= 1'b0;
            r_quad      <= 2'b00;
            r_pos       <= {POS_W{1'b0}};
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_btn_state <= BTN_IDLE;
            r_press_cnt <= {PC_W{1'b0}};
            r_btn_n     <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_div       <= w_div_nxt;
            r_remain    <= w_remain_nxt;
            r_dir       <= w_dir_nxt;
            r_quad      <= w_quad_nxt;
            r_pos       <= w_pos_nxt;
            r_done      <= w_done_nxt;
            r_busy      <= (w_state_nxt == ST_RUN);
            r_cmd_ready <= (w_state_nxt == ST_IDLE);
            r_btn_state <= w_btn_state_nxt;
            r_press_cnt <= w_press_cnt_nxt;
            r_btn_n     <= (w_btn_state_nxt != BTN_PRESS);
        end
    end

    assign cmd_if.cmd_ready = r_cmd_ready;
    assign o_quad_out       = r_quad;
    assign o_btn_n          = r_btn_n;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_pos            = r_pos;

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Directed self-checking bench for quad_encoder_emulator (STEP_DIV=4,
// PRESS_CYCLES=2, POS_W=16); inputs change and outputs are sampled 1ns after posedge.
module tb_quad_encoder_emulator;

    logic               clk;
    logic               rst;
    logic               btn_req;
    logic [1:0]         quad_out;
    logic               btn_n;
    logic               busy;
    logic               done;
    logic signed [15:0] pos;

    int checks;
    int errors;

    quad_encoder_emulator_if cmd_if ();

    quad_encoder_emulator #(
        .STEP_DIV    (4),
        .PRESS_CYCLES(2),
        .POS_W       (16)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .cmd_if    (cmd_if),
        .i_btn_req (btn_req),
        .o_quad_out(quad_out),
        .o_btn_n   (btn_n),
        .o_busy    (busy),
        .o_done    (done),
        .o_pos     (pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_if.cmd_valid = 1'($urandom_range(0, 1));
            cmd_if.cmd_dir   = 1'($urandom_range(0, 1));
            cmd_if.cmd_steps = 8'($urandom_range(0, 255));
            btn_req          = 1'($urandom_range(0, 1));
            tick();
        end
        checks++; if (quad_out !== 2'b00) begin errors++; $display("FAIL reset_quad got %b exp 00", quad_out); end
        checks++; if (btn_n !== 1'b1) begin errors++; $display("FAIL reset_btn_n got %b exp 1", btn_n); end
        checks++; if (cmd_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", cmd_if.cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (pos !== 16'sd0) begin errors++; $display("FAIL reset_pos got %0d exp 0", pos); end
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_dir   = 1'b0;
        cmd_if.cmd_steps = 8'd0;
        btn_req          = 1'b0;
        rst              = 1'b0;
        tick();
    endtask

    task automatic test_cw4();
        logic [1:0] seq [4];
        logic [1:0] exp_q;
        seq = '{2'b01, 2'b11, 2'b10, 2'b00};
        exp_q = 2'b00;
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_dir = 1'b1; cmd_if.cmd_steps = 8'd4;
        tick();
        cmd_if.cmd_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL cw4_busy got %b exp 1", busy); end
        checks++; if (cmd_if.cmd_ready !== 1'b0) begin errors++; $display("FAIL cw4_ready got %b exp 0", cmd_if.cmd_ready); end
        for (int t = 1; t <= 16; t++) begin
            tick();
            if (t % 4 == 0) exp_q = seq[t / 4 - 1];
            checks++; if (quad_out !== exp_q) begin errors++; $display("FAIL cw4_quad t=%0d got %b exp %b", t, quad_out, exp_q); end
            checks++; if (done !== (t == 16)) begin errors++; $display("FAIL cw4_done t=%0d got %b exp %b", t, done, (t == 16)); end
        end
        checks++; if (pos !== 16'sd4) begin errors++; $display("FAIL cw4_pos got %0d exp 4", pos); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cw4_busy_end got %b exp 0", busy); end
        checks++; if (cmd_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL cw4_ready_end got %b exp 1", cmd_if.cmd_ready); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL cw4_done_width got %b exp 0", done); end
    endtask

    task automatic test_ccw7();
        logic [1:0] seq [7];
        logic [1:0] exp_q;
        seq = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01};
        exp_q = 2'b00;
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_dir = 1'b0; cmd_if.cmd_steps = 8'd7;
        tick();
        cmd_if.cmd_valid = 1'b0;
        for (int t = 1; t <= 28; t++) begin
            tick();
            if (t % 4 == 0) exp_q = seq[t / 4 - 1];
            checks++; if (quad_out !== exp_q) begin errors++; $display("FAIL ccw7_quad t=%0d got %b exp %b", t, quad_out, exp_q); end
            checks++; if (done !== (t == 28)) begin errors++; $display("FAIL ccw7_done t=%0d got %b exp %b", t, done, (t == 28)); end
        end
        checks++; if (pos !== -16'sd3) begin errors++; $display("FAIL ccw7_pos got %0d exp -3", pos); end
    endtask

    task automatic test_zero_and_busy();
        // phase is 01 and pos is -3 on entry
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_dir = 1'b1; cmd_if.cmd_steps = 8'd0;
        tick();
        cmd_if.cmd_valid = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done got %b exp 1", done); end
        checks++; if (cmd_if.cmd_ready !== 1'b1) begin errors++; $display("FAIL zero_ready got %b exp 1", cmd_if.cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy got %b exp 0", busy); end
        checks++; if (quad_out !== 2'b01) begin errors++; $display("FAIL zero_quad got %b exp 01", quad_out); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_width got %b exp 0", done); end

        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_dir = 1'b1; cmd_if.cmd_steps = 8'd2;
        tick();
        cmd_if.cmd_dir = 1'b0; cmd_if.cmd_steps = 8'd5;
        for (int t = 1; t <= 8; t++) begin
            if (t == 4) cmd_if.cmd_valid = 1'b0;
            tick();
        end
        checks++; if (quad_out !== 2'b10) begin errors++; $display("FAIL busy_quad got %b exp 10", quad_out); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL busy_done got %b exp 1", done); end
        checks++; if (pos !== -16'sd1) begin errors++; $display("FAIL busy_pos got %0d exp -1", pos); end
        for (int t = 0; t < 6; t++) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_noqueue got %b exp 0", busy); end
        checks++; if (pos !== -16'sd1) begin errors++; $display("FAIL busy_pos_after got %0d exp -1", pos); end
    endtask

    task automatic test_back_to_back();
        // phase 10, pos -1; valid held high across two one-step CW commands
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_dir = 1'b1; cmd_if.cmd_steps = 8'd1;
        tick();
        for (int t = 0; t < 4; t++) tick();
        checks++; if (quad_out !== 2'b00) begin errors++; $display("FAIL b2b_quad1 got %b exp 00", quad_out); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done1 got %b exp 1", done); end
        tick();
        cmd_if.cmd_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy2 got %b exp 1", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_gap got %b exp 0", done); end
        for (int t = 0; t < 4; t++) tick();
        checks++; if (quad_out !== 2'b01) begin errors++; $display("FAIL b2b_quad2 got %b exp 01", quad_out); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done2 got %b exp 1", done); end
        checks++; if (pos !== 16'sd1) begin errors++; $display("FAIL b2b_pos got %0d exp 1", pos); end
        tick();
    endtask

    task automatic test_button();
        logic exp_a [4];
        logic exp_b [5];
        exp_a = '{1'b0, 1'b0, 1'b1, 1'b1};
        exp_b = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        // single press with a repeat request during the first low cycle
        for (int t = 0; t < 4; t++) begin
            btn_req = (t == 0 || t == 1);
            tick();
            checks++; if (btn_n !== exp_a[t]) begin errors++; $display("FAIL btn_press t=%0d got %b exp %b", t, btn_n, exp_a[t]); end
        end
        // request on the last low cycle is accepted as a new press
        for (int t = 0; t < 5; t++) begin
            btn_req = (t == 0 || t == 2);
            tick();
            checks++; if (btn_n !== exp_b[t]) begin errors++; $display("FAIL btn_rearm t=%0d got %b exp %b", t, btn_n, exp_b[t]); end
        end
        btn_req = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        // phase 01, pos 1; CW 6 steps with a simultaneous button request
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_dir = 1'b1; cmd_if.cmd_steps = 8'd6;
        btn_req = 1'b1;
        tick();
        cmd_if.cmd_valid = 1'b0;
        btn_req = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sim_busy got %b exp 1", busy); end
        checks++; if (btn_n !== 1'b0) begin errors++; $display("FAIL sim_btn_n got %b exp 0", btn_n); end
        for (int t = 0; t < 8; t++) tick();
        checks++; if (quad_out !== 2'b10) begin errors++; $display("FAIL mid_quad got %b exp 10", quad_out); end
        checks++; if (pos !== 16'sd3) begin errors++; $display("FAIL mid_pos got %0d exp 3", pos); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (quad_out !== 2'b00) begin errors++; $display("FAIL rst_mid_quad got %b exp 00", quad_out); end
        checks++; if (pos !== 16'sd0) begin errors++; $display("FAIL rst_mid_pos got %0d exp 0", pos); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy); end
        for (int t = 0; t < 20; t++) begin
            tick();
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_nodone t=%0d got %b exp 0", t, done); end
        end
        cmd_if.cmd_valid = 1'b1; cmd_if.cmd_dir = 1'b1; cmd_if.cmd_steps = 8'd1;
        tick();
        cmd_if.cmd_valid = 1'b0;
        for (int t = 0; t < 4; t++) tick();
        checks++; if (quad_out !== 2'b01) begin errors++; $display("FAIL post_quad got %b exp 01", quad_out); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL post_done got %b exp 1", done); end
        checks++; if (pos !== 16'sd1) begin errors++; $display("FAIL post_pos got %0d exp 1", pos); end
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rst              = 1'b1;
        btn_req          = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_dir   = 1'b0;
        cmd_if.cmd_steps = 8'd0;
        #2;
        test_reset();
        test_cw4();
        test_ccw7();
        test_zero_and_busy();
        test_back_to_back();
        test_button();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
